// File: rtl/adc_result_avg.sv
// Consumes self-timed SAR ADC conversions: synchronises adc_done, removes the calibrated
// comparator offset (when ADC_AVG_OFFSET_CORR_EN is defined), averages 2^N_LOG2 samples
// and presents each average on a valid/ready handshake.
module adc_result_avg #(
   parameter int RES_W  = 10,
   parameter int N_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adc_done,
   input  logic [RES_W-1:0] result,
   input  logic             cal,
   input  logic             avg_ready,
   output logic [RES_W-1:0] avg_out,
   output logic             avg_valid,
   output logic [RES_W:0]   offset_out,
   output logic             overrun
);

   localparam int ACC_W   = RES_W + N_LOG2;
   localparam int CNT_W   = (N_LOG2 > 0) ? N_LOG2 : 1;
   localparam int CNT_MAX = (1 << N_LOG2) - 1;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [2:0]       doneSync_q;
   logic [1:0]       calSync_q;
   logic             donePulse;

   logic             captVld_q;
   logic             isCal_q;
   logic [RES_W-1:0] sample_q;

   logic             corrVld_q;
   logic [RES_W-1:0] corr_q;
   logic [RES_W-1:0] corr_d;
   logic             calClear;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] accSum;
   logic             avgDone;
   logic [RES_W-1:0] avgNew;

   logic [0:0]       state_q, state_d;
   logic [RES_W-1:0] avgOut_q, avgOut_d;
   logic             overrun_q, overrun_d;

   // Two-flop synchronisers plus a third flop on done for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         doneSync_q <= '0;
         calSync_q  <= '0;
      end else begin
         doneSync_q <= {doneSync_q[1:0], adc_done};
         calSync_q  <= {calSync_q[0], cal};
      end
   end

   assign donePulse = doneSync_q[1] & ~doneSync_q[2];

   // CAPT stage: result is held stable by the ADC until the next conversion starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         captVld_q <= 1'b0;
         isCal_q   <= 1'b0;
         sample_q  <= '0;
      end else begin
         captVld_q <= donePulse;
         if (donePulse) begin
            sample_q <= result;
            isCal_q  <= calSync_q[1];
         end
      end
   end

   assign calClear = captVld_q & isCal_q;

`ifdef ADC_AVG_OFFSET_CORR_EN
   localparam logic [RES_W:0] MID_CODE = (RES_W+1)'(2 ** (RES_W - 1));

   logic [RES_W:0]   offset_q;
   logic [RES_W+1:0] corrFull;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_q <= '0;
      end else if (calClear) begin
         offset_q <= {1'b0, sample_q} - MID_CODE;
      end
   end

   // Corrected value spans -(2^(RES_W-1)-1) .. 1.5*2^RES_W, so the top two bits decide the clamp.
   always_comb begin
      corrFull = {2'b00, sample_q} - {offset_q[RES_W], offset_q};
      corr_d   = corrFull[RES_W-1:0];
      if (corrFull[RES_W+1]) begin
         corr_d = '0;
      end else if (corrFull[RES_W]) begin
         corr_d = '1;
      end
   end

   assign offset_out = offset_q;
`else
   always_comb begin
      corr_d = sample_q;
   end

   assign offset_out = '0;
`endif

   // CORR stage: calibration samples never reach the accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corrVld_q <= 1'b0;
         corr_q    <= '0;
      end else begin
         corrVld_q <= captVld_q & ~isCal_q;
         if (captVld_q & ~isCal_q) begin
            corr_q <= corr_d;
         end
      end
   end

   assign accSum = acc_q + ACC_W'(corr_q);
   assign avgNew = accSum[ACC_W-1:N_LOG2];

   // ACC stage: a calibration sample in CORR discards any partial block.
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      avgDone = 1'b0;
      if (corrVld_q) begin
         if (cnt_q == CNT_W'(CNT_MAX)) begin
            acc_d   = '0;
            cnt_d   = '0;
            avgDone = 1'b1;
         end else begin
            acc_d = accSum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (calClear) begin
         acc_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   // Single-entry output slot; a full, unaccepted slot drops new averages and flags overrun.
   always_comb begin
      state_d   = state_q;
      avgOut_d  = avgOut_q;
      overrun_d = overrun_q;
      case (state_q)
         EMPTY: begin
            if (avgDone) begin
               state_d  = FULL;
               avgOut_d = avgNew;
            end
         end
         default: begin
            if (avg_ready) begin
               if (avgDone) begin
                  avgOut_d = avgNew;
               end else begin
                  state_d = EMPTY;
               end
            end else if (avgDone) begin
               overrun_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         avgOut_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         avgOut_q  <= avgOut_d;
         overrun_q <= overrun_d;
      end
   end

   assign avg_out   = avgOut_q;
   assign avg_valid = (state_q == FULL);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_result_avg.sv
// Scoreboard bench for adc_result_avg: directed scenarios plus random conversions checked
// against a sample-level averaging model; mirrors ADC_AVG_OFFSET_CORR_EN in its model.
module tb_adc_result_avg;

   localparam int RES_W  = 10;
   localparam int N_LOG2 = 2;
   localparam int NBLK   = 1 << N_LOG2;
   localparam int MAXC   = (1 << RES_W) - 1;

`ifdef ADC_AVG_OFFSET_CORR_EN
   localparam bit USE_CORR = 1'b1;
`else
   localparam bit USE_CORR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             adcDone;
   logic [RES_W-1:0] result;
   logic             cal;
   logic             avgReady;
   logic [RES_W-1:0] avgOut;
   logic             avgValid;
   logic [RES_W:0]   offsetOut;
   logic             overrun;

   typedef struct {
      int value;
      int when;
   } exp_t;

   exp_t sbq[$];
   int   blk[$];
   int   modelOffset = 0;
   bit   expOverrun  = 1'b0;
   int   cyc         = 0;
   int   errors      = 0;
   int   checks      = 0;

   adc_result_avg #(.RES_W(RES_W), .N_LOG2(N_LOG2)) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_done   (adcDone),
      .result     (result),
      .cal        (cal),
      .avg_ready  (avgReady),
      .avg_out    (avgOut),
      .avg_valid  (avgValid),
      .offset_out (offsetOut),
      .overrun    (overrun)
   );

   // 10 ns system clock and a posedge counter used for latency checks.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One conversion: set cal/result, raise adc_done for two cycles, then idle for gap cycles.
   task automatic applyStimulus(input int code, input bit isCal, input int gap);
      int corr;
      int sum;
      @(posedge clk); #1;
      cal    = isCal;
      result = RES_W'(code);
      repeat (3) @(posedge clk);
      #1;
      adcDone = 1'b1;
      if (isCal) begin
         modelOffset = USE_CORR ? code - (1 << (RES_W - 1)) : 0;
         blk.delete();
      end else begin
         corr = code - modelOffset;
         if (corr < 0) corr = 0;
         if (corr > MAXC) corr = MAXC;
         blk.push_back(corr);
         if (blk.size() == NBLK) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            blk.delete();
            if (!avgReady && sbq.size() > 0) expOverrun = 1'b1;
            else sbq.push_back('{sum / NBLK, avgReady ? cyc + 5 : -1});
         end
      end
      repeat (2) @(posedge clk);
      #1;
      adcDone = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("scoreboard_drained", sbq.size(), 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_avg_out"}, avgOut, 0);
      checkOutput({tag, "_avg_valid"}, avgValid, 0);
      checkOutput({tag, "_offset_out"}, $signed(offsetOut), 0);
      checkOutput({tag, "_overrun"}, overrun, 0);
   endtask

   // Monitor: every negedge with valid&ready is one transfer at the next posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && avgValid && avgReady) begin
            if (sbq.size() == 0) begin
               checkOutput("spurious_valid", avgValid, 0);
            end else begin
               e = sbq.pop_front();
               checkOutput("avg_out", avgOut, e.value);
               if (e.when >= 0) checkOutput("avg_latency", cyc, e.when);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      adcDone  = 1'b0;
      result   = '0;
      cal      = 1'b0;
      avgReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;

      // Plain average with latency
      applyStimulus(100, 1'b0, 3);
      applyStimulus(102, 1'b0, 3);
      applyStimulus(104, 1'b0, 3);
      applyStimulus(106, 1'b0, 3);
      waitDrain();

      // Offset calibration and correction
      applyStimulus(612, 1'b1, 3);
      checkOutput("offset_plus100", $signed(offsetOut), modelOffset);
      repeat (4) applyStimulus(612, 1'b0, 2);
      waitDrain();

      // Clamp low
      repeat (4) applyStimulus(50, 1'b0, 2);
      waitDrain();

      // Clamp high
      applyStimulus(412, 1'b1, 3);
      checkOutput("offset_minus100", $signed(offsetOut), modelOffset);
      repeat (4) applyStimulus(1000, 1'b0, 2);
      waitDrain();

      // Overrun with consumer stalled
      applyStimulus(512, 1'b1, 3);
      @(posedge clk); #1;
      avgReady = 1'b0;
      repeat (8) applyStimulus(200, 1'b0, 2);
      repeat (8) applyStimulus(300, 1'b0, 2);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("stall_valid", avgValid, 1);
      checkOutput("stall_held_value", avgOut, (sbq.size() > 0) ? sbq[0].value : -1);
      checkOutput("stall_overrun", overrun, expOverrun);
      checkOutput("stall_queue_depth", sbq.size(), 1);
      avgReady = 1'b1;
      waitDrain();
      checkOutput("valid_falls_after_accept", avgValid, 0);
      checkOutput("overrun_sticky", overrun, expOverrun);

      // Partial block discarded by reset
      repeat (2) applyStimulus(400, 1'b0, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      blk.delete();
      modelOffset = 0;
      expOverrun  = 1'b0;
      @(posedge clk); #1;
      checkResetOutputs("midrst");
      rst = 1'b0;
      @(posedge clk); #1;
      checkResetOutputs("postrst");
      repeat (4) applyStimulus(800, 1'b0, 2);
      waitDrain();

      // Partial block discarded by calibration
      repeat (2) applyStimulus(400, 1'b0, 2);
      applyStimulus(512, 1'b1, 2);
      checkOutput("offset_zero", $signed(offsetOut), modelOffset);
      repeat (4) applyStimulus(800, 1'b0, 2);
      waitDrain();

      // Randomised conversions
      for (int n = 0; n < 48; n++) begin
         bit isCal;
         isCal = ($urandom_range(0, 7) == 0);
         applyStimulus(int'($urandom_range(0, MAXC)), isCal, int'($urandom_range(1, 4)));
         if (isCal) checkOutput("rand_offset", $signed(offsetOut), modelOffset);
      end
      waitDrain();
      checkOutput("final_overrun", overrun, expOverrun);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc_result_avg.md
# adc_result_avg

Downstream consumer of the 10-bit self-timed SAR ADC FSM. It runs in the system clock domain, synchronises the FSM's `adc_done`, and captures `result`. It stores a comparator-offset code from calibration conversions and subtracts it from normal conversions. It then averages 2^N_LOG2 corrected samples and presents each average on a valid/ready handshake to the digital back end.

## Interface
- `RES_W`, 10: ADC code width.
- `N_LOG2`, 2: log2 of samples per average; legal range 0..4.

- `clk`  in  1  system clock; all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `adc_done`  in  1  ADC FSM conversion-complete, asynchronous to `clk`.
- `result`  in  RES_W  ADC code; source holds it stable from `adc_done` rise until next `st_conv`.
- `cal`  in  1  quasi-static; high marks the conversion as a calibration conversion.
- `avg_ready`  in  1  consumer accepts `avg_out`.
- `avg_out`  out  RES_W  averaged corrected code.
- `avg_valid`  out  1  `avg_out` valid.
- `offset_out`  out  RES_W+1  signed stored offset, two's complement.
- `overrun`  out  1  sticky; an average was dropped.

## Operation
- Synchroniser: `adc_done` and `cal` each pass through 2 flops. `done_pulse` = sync2 & ~sync3, giving one pulse per conversion.
- Pipeline stage CAPT: on `done_pulse`, register `result` into `sample_r` and the synced `cal` into `is_cal_r`.
- Pipeline stage CORR, for a calibration sample:
  - `offset` <= `sample_r` − 2^(RES_W−1), signed RES_W+1 bits, range −512..+511.
  - Nothing is accumulated.
  - `acc` and `cnt` are cleared, so any partial block is discarded.
- Pipeline stage CORR, for a normal sample:
  - `corr` = `sample_r` − `offset`, computed signed in RES_W+2 bits.
  - `corr` is clamped to 0..2^RES_W−1 and registered.
- Pipeline stage ACC:
  - `acc` (RES_W+N_LOG2 bits, unsigned) += `corr`, and `cnt` (N_LOG2 bits) increments.
  - When `cnt` = 2^N_LOG2−1, compute (`acc`+`corr`) >> N_LOG2 (truncating), then clear `acc` and `cnt`.
  - If the output slot is free, load this value into `avg_out`.
- Output slot FSM:
  - States: EMPTY and FULL.
  - EMPTY→FULL when an average completes.
  - FULL→EMPTY when `avg_ready` is high.
  - FULL with `avg_ready` high and a new average completing in the same cycle: load the new value, stay FULL, no overrun.
  - FULL with `avg_ready` low and a new average completing: drop the new value, keep the old `avg_out`, set `overrun`.
- `overrun` clears only on `rst`.
- Back-to-back `done_pulse` at any spacing ≥ 1 cycle is supported; the pipeline never stalls.
- N_LOG2 = 0: every normal sample produces an average equal to `corr`.

## Timing
- Reset values: `avg_out`=0, `avg_valid`=0, `offset_out`=0, `overrun`=0, `acc`=0, `cnt`=0, all synchroniser flops 0, output FSM in EMPTY.
- `rst` mid-block: everything above is cleared immediately. A `done_pulse` already in flight is lost.
- Latency: E0 is the first posedge that samples `adc_done` high into sync1.
  - E1: sync2 high, `done_pulse` asserts.
  - E2: CAPT.
  - E3: CORR.
  - E4: ACC; `avg_valid` and `avg_out` update here for the final sample of a block.
  - The same E0..E4 timing applies to the calibration sample, with `offset_out` updating at E3.
- Handshake transfer occurs on a posedge with `avg_valid` & `avg_ready`. `avg_out` is stable while `avg_valid` is high and not accepted.
- A `cal` change takes effect for the `done_pulse` that follows 2 cycles after the change.

## Configuration
- `ADC_AVG_OFFSET_CORR_EN` defined: offset register and subtraction are present as described.
- `ADC_AVG_OFFSET_CORR_EN` undefined:
  - No offset register; `offset_out` tied to 0.
  - `corr` = `sample_r`, so no clamping is needed.
  - Calibration samples are still discarded and still clear `acc` and `cnt`.

## Test plan
All scenarios use N_LOG2=2, RES_W=10, and `avg_ready`=1 unless stated.
- Reset: assert `rst` mid-run → all outputs 0 during and after reset, with no `avg_valid` until 4 new conversions.
- Plain average: with no cal, conversions 100, 102, 104, 106 → `avg_out`=103 with a single `avg_valid` pulse, 4 clk cycles after E0 of the 4th conversion.
- Offset: a calibration conversion of 612 → `offset_out`=+100. Then 4 conversions of 612 → `avg_out`=512.
- Clamp, low: with offset +100, 4 conversions of 50 → `avg_out`=0.
- Clamp, high: a calibration conversion of 412 (offset −100), then 4 conversions of 1000 → `avg_out`=1023.
- Overrun: `avg_ready`=0 and 8 conversions of 200, then 8 of 300 → `avg_out` stays 200, `overrun`=1. Raising `avg_ready` accepts 200, then `avg_valid` falls.
- Partial block: 2 conversions of 400, then `rst` (or a calibration conversion), then 4 of 800 → `avg_out`=800 (with the calibration variant, a calibration conversion of 512 gives offset 0).
